// File: rtl/mem_io_responder.sv
// Memory-side responder for the SLC-3 memory request interface: steers each
// request to a synchronous BRAM or to the switch/hex I/O port and acknowledges it.
module mem_io_responder #(
    parameter int unsigned RD_LAT  = 2,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ena,
    input  logic        mem_wr_ena,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    output logic        bram_en,
    output logic        bram_we,
    output logic [15:0] bram_addr,
    output logic [15:0] bram_wdata,
    input  logic [15:0] bram_rdata,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_o
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q;
    logic            is_io_q;
    logic [DW-1:0]   io_q;
    logic [DW-1:0]   sw_meta;
    logic [DW-1:0]   sw_sync;
    logic            issue_c;
    logic            issue_io_c;

    // Next-state, latency counting and the combinational request/ack outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        issue_c    = 1'b0;
        issue_io_c = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_ena && !reset) begin
                    issue_c    = 1'b1;
                    issue_io_c = (mem_addr == IO_ADDR);
                    state_d    = BUSY;
                    cnt_d      = CW'(1);
                    if (mem_addr != IO_ADDR) begin
                        bram_en    = 1'b1;
                        bram_we    = mem_wr_ena;
                        bram_addr  = mem_addr;
                        bram_wdata = mem_wdata;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RD_LAT)) begin
                    cnt_d   = '0;
                    state_d = mem_ena ? HOLD : IDLE;
                    if (!reset) begin
                        mem_ack = 1'b1;
                        if (wr_q) begin
                            mem_rdata = '0;
                        end else if (is_io_q) begin
                            mem_rdata = io_q;
                        end else begin
                            mem_rdata = bram_rdata;
                        end
                    end
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (!mem_ena) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register, request capture, I/O registers and switch synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            is_io_q <= 1'b0;
            hex_o   <= '0;
            io_q    <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
            if (issue_c) begin
                wr_q    <= mem_wr_ena;
                is_io_q <= issue_io_c;
            end
            if (issue_io_c && mem_wr_ena) begin
                hex_o <= mem_wdata;
            end
            if (issue_io_c && !mem_wr_ena) begin
                io_q <= sw_sync;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized scoreboard bench for mem_io_responder with a BRAM model and a
// transaction-level reference model of memory, hex register and switches.
module tb_mem_io_responder;

    localparam int unsigned RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ena = 1'b0;
    logic        mem_wr_ena = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        bram_en;
    logic        bram_we;
    logic [15:0] bram_addr;
    logic [15:0] bram_wdata;
    logic [15:0] bram_rdata;
    logic [15:0] sw_i = '0;
    logic [15:0] hex_o;

    mem_io_responder #(.RD_LAT(RD_LAT), .IO_ADDR(16'hFFFF)) dut (
        .clk(clk), .reset(reset),
        .mem_ena(mem_ena), .mem_wr_ena(mem_wr_ena),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata),
        .sw_i(sw_i), .hex_o(hex_o)
    );

    always #5 clk = ~clk;

    // BRAM environment model: write at the enable edge, read data RD_LAT cycles later.
    logic [15:0] bram_mem [0:65535];
    logic [15:0] pipe [RD_LAT];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_wdata;
            pipe[0] <= bram_mem[bram_addr];
        end else begin
            pipe[0] <= 16'($urandom);
        end
        for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign bram_rdata = pipe[RD_LAT-1];

    // Reference model state
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_hex = '0;
    logic        exp_bram_en = 1'b0;
    logic        exp_bram_we = 1'b0;
    logic [15:0] exp_bram_addr = '0;
    logic [15:0] exp_bram_wdata = '0;
    int          sw_ready = 0;

    typedef struct {
        int          ack_cyc;
        logic [15:0] data;
    } exp_t;
    exp_t sc_q[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks the per-cycle outputs.
    always @(negedge clk) begin
        exp_t e;
        if (sc_q.size() > 0 && sc_q[0].ack_cyc < cyc) begin
            e = sc_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missing_ack: expected ack at cycle %0d, none by cycle %0d", e.ack_cyc, cyc);
        end
        if (mem_ack === 1'b1) begin
            if (sc_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ack at cycle %0d: got 1 expected 0", cyc);
            end else begin
                e = sc_q.pop_front();
                check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                check("rdata", 32'(mem_rdata), 32'(e.data));
            end
        end else begin
            check("ack_level", 32'(mem_ack), 32'd0);
            check("rdata_idle", 32'(mem_rdata), 32'd0);
        end
        check("bram_en", 32'(bram_en), 32'(exp_bram_en));
        check("bram_we", 32'(bram_we), 32'(exp_bram_we));
        check("bram_addr", 32'(bram_addr), 32'(exp_bram_addr));
        check("bram_wdata", 32'(bram_wdata), 32'(exp_bram_wdata));
        check("hex_o", 32'(hex_o), 32'(ref_hex));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [15:0] v);
        sw_i = v;
        sw_ready = cyc + 2;
    endtask

    // Issue the cycle-0 request and record what the reference model expects.
    task automatic issue(input logic [15:0] a, input logic w, input logic [15:0] d, output logic [15:0] new_hex);
        logic io;
        exp_t e;
        io = (a == 16'hFFFF);
        new_hex = ref_hex;
        mem_ena = 1'b1;
        mem_wr_ena = w;
        mem_addr = a;
        mem_wdata = d;
        exp_bram_en = !io;
        exp_bram_we = !io && w;
        exp_bram_addr = io ? 16'h0000 : a;
        exp_bram_wdata = io ? 16'h0000 : d;
        e.ack_cyc = cyc + int'(RD_LAT);
        e.data = w ? 16'h0000 : (io ? sw_i : ref_mem[a]);
        sc_q.push_back(e);
        if (w && io) new_hex = d;
        if (w && !io) ref_mem[a] = d;
    endtask

    task automatic txn(input logic [15:0] a, input logic w, input logic [15:0] d,
                       input int ena_len, input int gap);
        logic [15:0] nh;
        int total;
        if (a == 16'hFFFF && !w) begin
            while (cyc < sw_ready) step();
        end
        issue(a, w, d, nh);
        total = (ena_len > int'(RD_LAT) + 1) ? ena_len : int'(RD_LAT) + 1;
        for (int c = 1; c < total; c++) begin
            step();
            if (c == 1) begin
                ref_hex = nh;
                exp_bram_en = 1'b0;
                exp_bram_we = 1'b0;
                exp_bram_addr = '0;
                exp_bram_wdata = '0;
            end
            mem_ena = (c < ena_len);
            mem_addr = 16'($urandom);
            mem_wdata = 16'($urandom);
            mem_wr_ena = 1'($urandom);
        end
        for (int g = 0; g < gap; g++) begin
            step();
            mem_ena = 1'b0;
        end
        step();
    endtask

    // Reset lands in cycle 1 of a read; a BRAM read issues right after release.
    task automatic reset_mid_op();
        logic [15:0] nh;
        txn(16'hFFFF, 1'b1, 16'h1111, 1, 1);
        issue(16'h0005, 1'b0, 16'h0000, nh);
        step();
        reset = 1'b1;
        exp_bram_en = 1'b0;
        exp_bram_we = 1'b0;
        exp_bram_addr = '0;
        exp_bram_wdata = '0;
        step();
        sc_q.delete();
        ref_hex = '0;
        reset = 1'b0;
        sw_ready = cyc + 2;
        txn(16'h0010, 1'b0, 16'h0000, 3, 2);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            bram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < int'(RD_LAT); i++) pipe[i] = '0;
        bram_mem[16'h0010] = 16'h1234;
        ref_mem[16'h0010]  = 16'h1234;
        bram_mem[16'h0001] = 16'h0777;
        ref_mem[16'h0001]  = 16'h0777;

        repeat (3) step();
        reset = 1'b0;
        sw_ready = cyc + 2;
        step();

        txn(16'h0010, 1'b0, 16'h0000, 3, 1);
        txn(16'h0042, 1'b1, 16'hBEEF, 3, 1);
        txn(16'h0042, 1'b0, 16'h0000, 3, 1);
        txn(16'hFFFF, 1'b1, 16'h00AB, 3, 1);
        set_sw(16'h5A5A);
        step();
        txn(16'hFFFF, 1'b0, 16'h0000, 3, 1);
        txn(16'h0001, 1'b0, 16'h0000, 8, 1);
        txn(16'hFFFE, 1'b1, 16'hCAFE, 1, 2);
        txn(16'hFFFE, 1'b0, 16'h0000, 2, 1);
        reset_mid_op();

        for (int n = 0; n < 250; n++) begin
            int r;
            logic [15:0] a;
            if ($urandom_range(0, 4) == 0) set_sw(16'($urandom));
            r = int'($urandom_range(0, 9));
            if (r < 5)       a = 16'($urandom_range(0, 15));
            else if (r < 7)  a = 16'hFFFF;
            else if (r == 7) a = 16'hFFFE;
            else             a = 16'($urandom);
            txn(a, 1'($urandom), 16'($urandom),
                int'($urandom_range(1, 8)), int'($urandom_range(1, 3)));
        end

        repeat (RD_LAT + 3) step();
        if (sc_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d acks outstanding, expected 0", sc_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
